// File: rtl/alu_pkg.sv
// Shared ALU op codes and default widths for the execute-stage controller.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_REG_W  = 5;
  localparam int unsigned ALU_OP_W   = 6;

  localparam logic [ALU_OP_W-1:0] ALU_NOP   = 6'd0;
  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 6'd1;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 6'd2;
  localparam logic [ALU_OP_W-1:0] ALU_STORE = 6'd3;
  localparam logic [ALU_OP_W-1:0] ALU_LOAD  = 6'd4;

endpackage

// File: rtl/alu_fwd_mux.sv
// One source-operand forwarding selector: EX/MEM beats WB beats the register file.
module alu_fwd_mux
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned REG_W  = ALU_REG_W
) (
  input  logic [REG_W-1:0]  idx,
  input  logic [DATA_W-1:0] rf_val,
  input  logic              ex_hit_en,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              wb_en,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] operand
);

  // r0 is never forwarded so a discarded write to it cannot leak through.
  always_comb begin
    operand = rf_val;
    if (idx != '0) begin
      if (ex_hit_en && (ex_rd == idx)) begin
        operand = ex_data;
      end else if (wb_en && (wb_rd == idx)) begin
        operand = wb_data;
      end
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: forwards operands, drives the shared ALU,
// registers its result into EX/MEM and holds consumers of loads.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W           = ALU_DATA_W,
  parameter int unsigned REG_W            = ALU_REG_W,
  parameter int unsigned OP_W             = ALU_OP_W,
  parameter int unsigned LOAD_USE_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [OP_W-1:0]   id_op,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rs_val,
  input  logic [DATA_W-1:0] id_rt_val,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_wr_en,
  input  logic              wb_wr_en,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_imm,
  output logic [OP_W-1:0]   alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_result,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_rd,
  output logic              ex_wr_en,
  output logic [OP_W-1:0]   ex_op
);

  localparam logic [2:0] BubbleLoad = 3'(LOAD_USE_BUBBLES);

  logic [2:0]        cnt_q;
  logic [REG_W-1:0]  pend_rd_q;
  logic [DATA_W-1:0] opnd_rs, opnd_rt;
  logic              ex_is_load, ex_fwd_en;
  logic              load_in_ex, load_pend, hazard;
  logic              accept, drain;

  // A load's EX/MEM value is an address, never data, so it is not forwarded.
  assign ex_is_load = ex_wr_en && (ex_op == OP_W'(ALU_LOAD));
  assign ex_fwd_en  = ex_valid && ex_wr_en && (ex_op != OP_W'(ALU_LOAD));

  alu_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
    .idx       (id_rs),
    .rf_val    (id_rs_val),
    .ex_hit_en (ex_fwd_en),
    .ex_rd     (ex_rd),
    .ex_data   (ex_result),
    .wb_en     (wb_wr_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .operand   (opnd_rs)
  );

  alu_fwd_mux #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
    .idx       (id_rt),
    .rf_val    (id_rt_val),
    .ex_hit_en (ex_fwd_en),
    .ex_rd     (ex_rd),
    .ex_data   (ex_result),
    .wb_en     (wb_wr_en),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .operand   (opnd_rt)
  );

  assign load_in_ex = ex_valid && ex_is_load && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (ex_rd == id_rt));
  assign load_pend  = (cnt_q != '0) && (pend_rd_q != '0) &&
                      ((pend_rd_q == id_rs) || (pend_rd_q == id_rt));
  assign hazard     = load_in_ex || load_pend;

  assign id_ready = rst_n && !hazard && (!ex_valid || ex_ready);
  assign accept   = id_valid && id_ready;
  assign drain    = ex_valid && ex_ready;

  assign alu_a    = opnd_rs;
  assign alu_b    = opnd_rt;
  assign alu_imm  = id_imm;
  assign alu_ctrl = accept ? id_op : OP_W'(ALU_NOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_result     <= '0;
      ex_store_data <= '0;
      ex_rd         <= '0;
      ex_wr_en      <= 1'b0;
      ex_op         <= '0;
      cnt_q         <= '0;
      pend_rd_q     <= '0;
    end else begin
      if (accept) begin
        // A NOP is consumed without occupying EX/MEM.
        ex_valid      <= (id_op != OP_W'(ALU_NOP));
        ex_result     <= alu_result;
        ex_store_data <= opnd_rt;
        ex_rd         <= id_rd;
        ex_wr_en      <= id_wr_en;
        ex_op         <= id_op;
      end else if (drain) begin
        ex_valid <= 1'b0;
      end

      if (drain && ex_is_load) begin
        cnt_q     <= BubbleLoad;
        pend_rd_q <= ex_rd;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 3'd1;
      end
    end
  end

endmodule
